dmac_channel_arbiter: RTL and testbench
=======================================

// Module: dmac_channel_arbiter
// PURPOSE
//  Sequencer/arbiter in front of the DMAC transfer datapath. Picks one pending
//  peripheral request (DmacReq & ch_en), runs the Bus_Req/Bus_Grant handshake
//  with the system AHB arbiter, and starts, pauses, resumes and aborts the datapath.
//  On completion it closes a 4-phase ReqAck handshake with the peripheral and
//  pulses a per-channel interrupt. One channel is active at a time.
// PARAMETERS
//  NUM_CH         2   number of DMA channels / peripheral request lines (>=2)
//  CH_W           1   width of ch_sel, $clog2(NUM_CH)
//  RR_MODE        1   1 = round-robin arbitration, 0 = fixed (lowest index wins)
//  BEAT_W         16  width of beat_count status counter
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst          in   1       synchronous reset, active-high
//  DmacReq      in   NUM_CH  peripheral request lines, level
//  ch_en        in   NUM_CH  channel enable bits from the config register block
//  Bus_Grant    in   1       grant from system AHB arbiter, level
//  xfer_done    in   1       datapath pulse: active channel size count reached 0
//  beat_valid   in   1       datapath pulse: one data beat completed
//  Bus_Req      out  1       bus request to system arbiter
//  ch_sel       out  CH_W    index of active channel (muxes channel regs)
//  xfer_start   out  1       1-cycle pulse: datapath loads regs of ch_sel and begins
//  xfer_hold    out  1       datapath must stall (grant lost), MTrans forced IDLE
//  xfer_abort   out  1       1-cycle pulse: datapath discards transfer
//  ReqAck       out  NUM_CH  acknowledge to peripheral, one-hot or zero
//  ch_irq       out  NUM_CH  1-cycle completion pulse per channel
//  beat_count   out  BEAT_W  beats of current/last transfer, saturating
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, rr_ptr=NUM_CH-1 (ch0 wins first), ch_sel=0.
//  pend = DmacReq & ch_en. Winner: fixed -> lowest set index; RR -> first set
//  index after rr_ptr, wrapping modulo NUM_CH.
//  Bus_Req=1 in REQ, START, XFER, HOLD; 0 in IDLE, DONE. Outputs are registered.
//  IDLE : pend!=0 -> latch winner into ch_sel, clear beat_count, -> REQ (next cycle).
//  REQ  : Bus_Grant=1 -> START. Waits indefinitely otherwise.
//  START: xfer_start=1 for exactly this cycle -> XFER. Min request-to-start = 3 clks
//         (IDLE->REQ->START with grant already high).
//  XFER : beat_valid increments beat_count (saturate at all-ones).
//         Priority: abort > xfer_done > grant loss.
//         xfer_done -> DONE; else !Bus_Grant -> HOLD.
//  HOLD : xfer_hold=1, Bus_Req stays 1. Bus_Grant=1 -> XFER (hold drops same edge).
//         xfer_done in HOLD is still honoured -> DONE. beat_valid ignored.
//  DONE : ReqAck[ch_sel]=1 held; ch_irq[ch_sel]=1 only on the entry cycle.
//         Stays until DmacReq[ch_sel]==0, then ReqAck cleared, rr_ptr<=ch_sel, -> IDLE.
//         New arbitration happens only from IDLE (>=1 idle cycle between transfers).
//  Abort: ch_en[ch_sel]==0 in REQ/START/XFER/HOLD -> xfer_abort pulse, -> IDLE.
//         No ReqAck, no ch_irq, rr_ptr unchanged. ch_en is not checked in DONE.
//  DmacReq[ch_sel] dropping before DONE has no effect (transfer runs to completion).
//  Simultaneous xfer_done and Bus_Grant fall in XFER -> DONE (done wins).
//  rst asserted in any state -> IDLE next edge, all outputs 0, no pulses emitted.
// TESTING
//  T1 single: ch_en=01, DmacReq=01, grant after 4 clks, done after 10 beats ->
//     xfer_start 1 clk after grant, beat_count=10, ch_irq=01 1 clk, ReqAck=01 until req drops.
//  T2 RR: DmacReq=11 held, ch_en=11, RR_MODE=1 -> serve order ch0,ch1,ch0; each
//     waits for ReqAck handshake; with RR_MODE=0 order is ch0,ch0,ch0.
//  T3 grant loss: drop Bus_Grant 2 clks after 3 beats -> HOLD, xfer_hold=1,
//     Bus_Req=1, beats frozen at 3; regrant -> XFER, done at 10 beats, count=10.
//  T4 abort: clear ch_en[1] while ch1 in XFER -> xfer_abort 1 clk, Bus_Req=0,
//     ReqAck=00, ch_irq=00; pending ch0 served next.
//  T5 corner: xfer_done coincident with Bus_Grant fall -> DONE, not HOLD;
//     xfer_done during HOLD -> DONE.
//  T6 reset: assert rst in XFER and in DONE -> next clk all outputs 0,
//     state IDLE, ch0 wins next arbitration.

Source files
------------

// File: rtl/dmac_channel_arbiter.sv
// DMAC channel sequencer/arbiter.
// Selects one pending, enabled peripheral request and runs the system-bus
// Bus_Req/Bus_Grant handshake. It drives start/hold/abort to the transfer
// datapath. On completion it closes the 4-phase ReqAck handshake with the
// peripheral and pulses that channel's interrupt.
// Only one channel is active at a time, and every output is registered.
module dmac_channel_arbiter #(
   parameter int NUM_CH  = 2,
   parameter int CH_W    = 1,
   parameter int RR_MODE = 1,
   parameter int BEAT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] DmacReq,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              Bus_Grant,
   input  logic              xfer_done,
   input  logic              beat_valid,
   output logic              Bus_Req,
   output logic [CH_W-1:0]   ch_sel,
   output logic              xfer_start,
   output logic              xfer_hold,
   output logic              xfer_abort,
   output logic [NUM_CH-1:0] ReqAck,
   output logic [NUM_CH-1:0] ch_irq,
   output logic [BEAT_W-1:0] beat_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_START,
      S_XFER,
      S_HOLD,
      S_DONE
   } state_t;

   state_t            state;
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   winner;
   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] sel_onehot;
   logic              busy;
   logic              abort;

   assign pend       = DmacReq & ch_en;
   assign sel_onehot = NUM_CH'(1) << ch_sel;
   assign busy       = (state == S_REQ) || (state == S_START) ||
                       (state == S_XFER) || (state == S_HOLD);
   // Disabling the active channel cancels it anywhere before completion.
   assign abort      = busy && !ch_en[ch_sel];

   // i-th candidate in search order: after rr_ptr (round-robin) or from 0 (fixed).
   function automatic logic [CH_W-1:0] cand(input logic [CH_W-1:0] ptr, input int i);
      if (RR_MODE != 0) return CH_W'((int'(ptr) + 1 + i) % NUM_CH);
      return CH_W'(i);
   endfunction

   // Winner search: scan from last to first candidate so the earliest one sticks.
   always_comb begin
      // NOTE: assign a default before any conditional write so no latch is inferred.
      winner = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (pend[cand(rr_ptr, i)]) winner = cand(rr_ptr, i);
      end
   end

   // Sequencer FSM with registered outputs; the pulses self-clear every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         rr_ptr     <= CH_W'(NUM_CH - 1);
         ch_sel     <= '0;
         Bus_Req    <= 1'b0;
         xfer_start <= 1'b0;
         xfer_hold  <= 1'b0;
         xfer_abort <= 1'b0;
         ReqAck     <= '0;
         ch_irq     <= '0;
         beat_count <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         xfer_start <= 1'b0;
         xfer_abort <= 1'b0;
         ch_irq     <= '0;

         if (state == S_XFER && beat_valid && beat_count != '1)
            beat_count <= beat_count + BEAT_W'(1);

         if (abort) begin
            xfer_abort <= 1'b1;
            Bus_Req    <= 1'b0;
            xfer_hold  <= 1'b0;
            state      <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (|pend) begin
                     ch_sel     <= winner;
                     beat_count <= '0;
                     Bus_Req    <= 1'b1;
                     state      <= S_REQ;
                  end
               end
               S_REQ: begin
                  if (Bus_Grant) begin
                     xfer_start <= 1'b1;
                     state      <= S_START;
                  end
               end
               S_START: state <= S_XFER;
               S_XFER: begin
                  if (xfer_done) begin
                     Bus_Req <= 1'b0;
                     ReqAck  <= sel_onehot;
                     ch_irq  <= sel_onehot;
                     state   <= S_DONE;
                  end else if (!Bus_Grant) begin
                     xfer_hold <= 1'b1;
                     state     <= S_HOLD;
                  end
               end
               S_HOLD: begin
                  if (xfer_done) begin
                     xfer_hold <= 1'b0;
                     Bus_Req   <= 1'b0;
                     ReqAck    <= sel_onehot;
                     ch_irq    <= sel_onehot;
                     state     <= S_DONE;
                  end else if (Bus_Grant) begin
                     xfer_hold <= 1'b0;
                     state     <= S_XFER;
                  end
               end
               S_DONE: begin
                  if (!DmacReq[ch_sel]) begin
                     ReqAck <= '0;
                     rr_ptr <= ch_sel;
                     state  <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dmac_channel_arbiter.sv
// Scoreboard bench for dmac_channel_arbiter.
// Stimulus pushes the expected start/done/abort events. A monitor pops and
// compares them as the DUT pulses xfer_start, ch_irq or xfer_abort.
// A second instance with fixed priority runs the fixed-priority serve-order case.
module tb_dmac_channel_arbiter;

   localparam int NUM_CH = 2;
   localparam int CH_W   = 1;
   localparam int BEAT_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NUM_CH-1:0] dmac_req, dmac_req_fx, ch_en;
   logic              bus_grant, xfer_done, beat_valid;

   logic              bus_req, xfer_start, xfer_hold, xfer_abort;
   logic [CH_W-1:0]   ch_sel;
   logic [NUM_CH-1:0] req_ack, ch_irq;
   logic [BEAT_W-1:0] beat_count;

   logic              bus_req_fx, xfer_start_fx, xfer_hold_fx, xfer_abort_fx;
   logic [CH_W-1:0]   ch_sel_fx;
   logic [NUM_CH-1:0] req_ack_fx, ch_irq_fx;
   logic [BEAT_W-1:0] beat_count_fx;

   int n_checks = 0;
   int n_pass   = 0;

   typedef enum int {EV_START, EV_DONE, EV_ABORT} ev_e;
   typedef struct {
      ev_e kind;
      int  ch;
      int  beats;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   dmac_channel_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W), .RR_MODE(1), .BEAT_W(BEAT_W)) dut (
      .clk(clk), .rst(rst), .DmacReq(dmac_req), .ch_en(ch_en), .Bus_Grant(bus_grant),
      .xfer_done(xfer_done), .beat_valid(beat_valid), .Bus_Req(bus_req), .ch_sel(ch_sel),
      .xfer_start(xfer_start), .xfer_hold(xfer_hold), .xfer_abort(xfer_abort),
      .ReqAck(req_ack), .ch_irq(ch_irq), .beat_count(beat_count)
   );

   dmac_channel_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W), .RR_MODE(0), .BEAT_W(BEAT_W)) dut_fx (
      .clk(clk), .rst(rst), .DmacReq(dmac_req_fx), .ch_en(ch_en), .Bus_Grant(bus_grant),
      .xfer_done(xfer_done), .beat_valid(beat_valid), .Bus_Req(bus_req_fx), .ch_sel(ch_sel_fx),
      .xfer_start(xfer_start_fx), .xfer_hold(xfer_hold_fx), .xfer_abort(xfer_abort_fx),
      .ReqAck(req_ack_fx), .ch_irq(ch_irq_fx), .beat_count(beat_count_fx)
   );

   function automatic logic [NUM_CH-1:0] onehot(input int c);
      return NUM_CH'(1) << c;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic push(input ev_e k, input int ch, input int beats);
      exp_t e;
      e.kind  = k;
      e.ch    = ch;
      e.beats = beats;
      exp_q.push_back(e);
   endtask

   // Monitor: every output event consumes one expected entry.
   always @(negedge clk) begin : mon
      exp_t e;
      if (xfer_start || (|ch_irq) || xfer_abort) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            if (xfer_start) begin
               check("ev_kind_start", e.kind, EV_START);
               check("start_ch_sel", ch_sel, e.ch);
               check("start_bus_req", bus_req, 1);
            end else if (|ch_irq) begin
               check("ev_kind_done", e.kind, EV_DONE);
               check("done_ch_irq", ch_irq, onehot(e.ch));
               check("done_req_ack", req_ack, onehot(e.ch));
               check("done_beats", beat_count, e.beats);
               check("done_bus_req", bus_req, 0);
            end else begin
               check("ev_kind_abort", e.kind, EV_ABORT);
               check("abort_ch_sel", ch_sel, e.ch);
               check("abort_req_ack", req_ack, 0);
               check("abort_ch_irq", ch_irq, 0);
               check("abort_bus_req", bus_req, 0);
            end
         end
      end
   end

   // Waits (bounded) for xfer_start; returns at that negedge with cycles spent.
   task automatic wait_start(output int cyc);
      logic seen = 1'b0;
      cyc = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         cyc++;
         if (xfer_start) seen = 1'b1;
      end
      check("start_seen", seen, 1);
   endtask

   task automatic run_beats(input int n);
      beat_valid = 1'b1;
      repeat (n) @(negedge clk);
      beat_valid = 1'b0;
   endtask

   task automatic pulse_done();
      xfer_done = 1'b1;
      @(negedge clk);
      xfer_done = 1'b0;
   endtask

   // Peripheral side of the handshake: see ReqAck, drop the request.
   task automatic ack_drop(input string name, input logic [NUM_CH-1:0] exp_ack);
      check({name, "_ack"}, req_ack, exp_ack);
      dmac_req = dmac_req & ~exp_ack;
      @(negedge clk);
      check({name, "_ack_clr"}, req_ack, 0);
   endtask

   task automatic check_zero(input string name);
      check({name, "_bus_req"}, bus_req, 0);
      check({name, "_ch_sel"}, ch_sel, 0);
      check({name, "_start"}, xfer_start, 0);
      check({name, "_hold"}, xfer_hold, 0);
      check({name, "_abort"}, xfer_abort, 0);
      check({name, "_req_ack"}, req_ack, 0);
      check({name, "_ch_irq"}, ch_irq, 0);
      check({name, "_beats"}, beat_count, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      int order[3];
      rst = 1'b1; dmac_req = '0; dmac_req_fx = '0; ch_en = '0;
      bus_grant = 1'b0; xfer_done = 1'b0; beat_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // T1: single transfer, grant arrives late.
      push(EV_START, 0, 0);
      push(EV_DONE, 0, 10);
      ch_en = 2'b01; dmac_req = 2'b01;
      repeat (4) @(negedge clk);
      check("t1_req_waiting", bus_req, 1);
      check("t1_no_start", xfer_start, 0);
      bus_grant = 1'b1;
      wait_start(cyc);
      check("t1_start_latency", cyc, 1);
      @(negedge clk);
      check("t1_start_pulse_len", xfer_start, 0);
      run_beats(10);
      pulse_done();
      @(negedge clk);
      check("t1_irq_one_cycle", ch_irq, 0);
      check("t1_ack_held", req_ack, 2'b01);
      @(negedge clk);
      ack_drop("t1", 2'b01);
      check("t1_idle_bus_req", bus_req, 0);

      // T2: both channels requesting; RR order 0,1,0 and fixed order 0,0,0.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      order = '{0, 1, 0};
      for (int k = 0; k < 3; k++) begin
         push(EV_START, order[k], 0);
         push(EV_DONE, order[k], 2);
      end
      ch_en = 2'b11; dmac_req = 2'b11; dmac_req_fx = 2'b11;
      for (int k = 0; k < 3; k++) begin
         wait_start(cyc);
         check("t2_fx_start", xfer_start_fx, 1);
         check("t2_fx_sel", ch_sel_fx, 0);
         @(negedge clk);
         run_beats(2);
         pulse_done();
         check("t2_ack", req_ack, onehot(order[k]));
         check("t2_fx_ack", req_ack_fx, 2'b01);
         dmac_req    = dmac_req & ~onehot(order[k]);
         dmac_req_fx = dmac_req_fx & ~2'b01;
         @(negedge clk);
         check("t2_ack_clr", req_ack, 0);
         if (k < 2) begin
            dmac_req = 2'b11; dmac_req_fx = 2'b11;
         end
      end
      dmac_req = '0; dmac_req_fx = '0;
      @(negedge clk);

      // T3: grant lost mid-transfer, beats frozen during hold.
      push(EV_START, 1, 0);
      push(EV_DONE, 1, 10);
      dmac_req = 2'b10;
      wait_start(cyc);
      @(negedge clk);
      run_beats(3);
      repeat (2) @(negedge clk);
      bus_grant = 1'b0;
      @(negedge clk);
      check("t3_hold", xfer_hold, 1);
      check("t3_hold_bus_req", bus_req, 1);
      check("t3_hold_beats", beat_count, 3);
      beat_valid = 1'b1;
      repeat (2) @(negedge clk);
      check("t3_beats_frozen", beat_count, 3);
      beat_valid = 1'b0; bus_grant = 1'b1;
      @(negedge clk);
      check("t3_hold_released", xfer_hold, 0);
      run_beats(7);
      pulse_done();
      ack_drop("t3", 2'b10);

      // T4: ch1 aborted by clearing its enable; pending ch0 served next.
      push(EV_START, 1, 0);
      push(EV_ABORT, 1, 0);
      push(EV_START, 0, 0);
      push(EV_DONE, 0, 1);
      dmac_req = 2'b10;
      wait_start(cyc);
      @(negedge clk);
      dmac_req = 2'b11;
      run_beats(2);
      ch_en = 2'b01;
      @(negedge clk);
      check("t4_abort", xfer_abort, 1);
      check("t4_abort_bus_req", bus_req, 0);
      check("t4_abort_irq", ch_irq, 0);
      @(negedge clk);
      check("t4_abort_pulse_len", xfer_abort, 0);
      check("t4_rearb_bus_req", bus_req, 1);
      wait_start(cyc);
      @(negedge clk);
      run_beats(1);
      pulse_done();
      ack_drop("t4", 2'b01);
      dmac_req = '0; ch_en = 2'b11;
      @(negedge clk);

      // T5a: xfer_done coincident with grant fall -> DONE.
      push(EV_START, 0, 0);
      push(EV_DONE, 0, 1);
      dmac_req = 2'b01;
      wait_start(cyc);
      @(negedge clk);
      run_beats(1);
      bus_grant = 1'b0; xfer_done = 1'b1;
      @(negedge clk);
      xfer_done = 1'b0;
      check("t5a_no_hold", xfer_hold, 0);
      bus_grant = 1'b1;
      ack_drop("t5a", 2'b01);

      // T5b: xfer_done while holding -> DONE.
      push(EV_START, 1, 0);
      push(EV_DONE, 1, 2);
      dmac_req = 2'b10;
      wait_start(cyc);
      @(negedge clk);
      run_beats(2);
      bus_grant = 1'b0;
      @(negedge clk);
      check("t5b_hold", xfer_hold, 1);
      pulse_done();
      check("t5b_hold_cleared", xfer_hold, 0);
      bus_grant = 1'b1;
      ack_drop("t5b", 2'b10);

      // T6: reset in XFER (with rr pointing at ch0) and in DONE.
      push(EV_START, 0, 0);
      push(EV_DONE, 0, 1);
      push(EV_START, 1, 0);
      push(EV_START, 0, 0);
      push(EV_DONE, 0, 2);
      dmac_req = 2'b11;
      wait_start(cyc);
      @(negedge clk);
      run_beats(1);
      pulse_done();
      dmac_req = 2'b10;
      @(negedge clk);
      dmac_req = 2'b11;
      wait_start(cyc);
      @(negedge clk);
      run_beats(2);
      rst = 1'b1;
      @(negedge clk);
      check_zero("t6_xfer_rst");
      rst = 1'b0;
      wait_start(cyc);
      @(negedge clk);
      run_beats(2);
      pulse_done();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_zero("t6_done_rst");
      dmac_req = '0; rst = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_idle_bus_req", bus_req, 0);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
